reset_sequencer: RTL

- Receiving end of a reset request.
- Takes a raw active-high reset request from a pulse generator, button or watchdog, synchronizes it and qualifies its width.
- Drives a staged set of per-domain active-high resets, released in order. Each stage waits for an acknowledge from its domain before the next stage is released.
- Sits between the board/testbench reset source and the functional blocks (LCD, UART, DAC controllers).

---
 rtl/reset_pkg.sv | 28 ++
 rtl/reset_req_sync.sv | 52 +++++
 rtl/reset_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Purpose: shared types and defaults for the staged reset sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package reset_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      RELEASE,
      WAIT_ACK,
      GAP
   } seq_state_t;

   // Default timing and sizing
   localparam int DEF_NUM_STAGES     = 3;
   localparam int DEF_MIN_PULSE      = 4;
   localparam int DEF_HOLD_CYCLES    = 40;
   localparam int DEF_GAP_CYCLES     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int REQ_COUNT_W        = 8;

   // Width of a counter that must hold the value n (never narrower than 1 bit)
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Purpose: 2-flop synchronizer for the raw reset request plus a minimum-width qualifier.
// Latency: accept pulse 2 sync cycles + MIN_PULSE cycles after the raw request rises.
// Backpressure: none; one accept pulse per qualifying high pulse, short pulses dropped.
module reset_req_sync
   import reset_pkg::*;
#(
   parameter int MIN_PULSE = DEF_MIN_PULSE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_async,
   output logic req_sync,
   output logic req_accept
);

   localparam int             CW      = cnt_w(MIN_PULSE);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_PULSE);
   localparam logic [CW-1:0]  CNT_ARM = CW'(MIN_PULSE - 1);

   logic          sync0_q, sync1_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept_q, accept_d;

   // Count consecutive synchronized-high cycles; fire once when the count reaches MIN_PULSE
   always_comb begin
      cnt_d    = '0;
      accept_d = 1'b0;
      if (sync1_q) begin
         cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
         accept_d = (cnt_q == CNT_ARM);
      end
   end

   // Synchronizer, qualifier counter and accept pulse registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync0_q  <= 1'b0;
         sync1_q  <= 1'b0;
         cnt_q    <= '0;
         accept_q <= 1'b0;
      end else begin
         sync0_q  <= req_async;
         sync1_q  <= sync0_q;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
      end
   end

   assign req_sync   = sync1_q;
   assign req_accept = accept_q;

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: staged per-domain reset release, each stage gated by its domain ACK (optional ACK timeout: RESET_SEQ_TIMEOUT_EN).
// Latency: stage k falls HOLD_CYCLES + k*(GAP_CYCLES+2) + 1 cycles after request acceptance when ACKs are immediate.
// Backpressure: a missing ACK stalls the sequence indefinitely (or until timeout when enabled); a new request restarts it.
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int MIN_PULSE      = DEF_MIN_PULSE,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RST_REQ,
   input  logic [NUM_STAGES-1:0]  STAGE_ACK,
   output logic [NUM_STAGES-1:0]  STAGE_RST,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [REQ_COUNT_W-1:0] REQ_COUNT
`ifdef RESET_SEQ_TIMEOUT_EN
   ,
   output logic                   TIMEOUT_ERR
`endif
);

   localparam int                HOLD_W    = cnt_w(HOLD_CYCLES);
   localparam int                GAP_W     = cnt_w(GAP_CYCLES);
   localparam int                IDX_W     = $clog2(NUM_STAGES) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);

   if (NUM_STAGES < 1 || NUM_STAGES > 8 || MIN_PULSE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("reset_sequencer: illegal parameter value");
   end

   logic req_sync, req_accept;

   reset_req_sync #(
      .MIN_PULSE (MIN_PULSE)
   ) u_req_sync (
      .clk        (CLK),
      .rst_n      (RST),
      .req_async  (RST_REQ),
      .req_sync   (req_sync),
      .req_accept (req_accept)
   );

   seq_state_t             state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [REQ_COUNT_W-1:0] req_count_q, req_count_d;
   logic                   ack_sel, ack_ok;

`ifdef RESET_SEQ_TIMEOUT_EN
   localparam int               TO_W    = cnt_w(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            to_hit;
`endif

   // Next-state logic: acceptance overrides everything, otherwise walk HOLD -> (RELEASE -> WAIT_ACK -> GAP)* -> IDLE
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      idx_d       = idx_q;
      stage_rst_d = stage_rst_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      req_count_d = req_count_q;

      // Only the ACK of the stage currently being released is looked at
      ack_sel = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (idx_q == IDX_W'(k)) ack_sel = STAGE_ACK[k];
      end

`ifdef RESET_SEQ_TIMEOUT_EN
      wait_cnt_d    = '0;
      timeout_err_d = timeout_err_q;
      to_hit        = (wait_cnt_q == TO_LAST) && !ack_sel;
      ack_ok        = ack_sel || to_hit;
`else
      ack_ok        = ack_sel;
`endif

      if (req_accept) begin
         state_d     = HOLD;
         hold_cnt_d  = '0;
         stage_rst_d = '1;
         busy_d      = 1'b1;
         if (req_count_q != '1) req_count_d = req_count_q + REQ_COUNT_W'(1);
      end else begin
         case (state_q)
            IDLE: begin
               busy_d = 1'b0;
            end
            HOLD: begin
               // A request still held high keeps restarting the hold window
               if (req_sync) begin
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_d = RELEASE;
                  idx_d   = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            RELEASE: begin
               state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (ack_ok) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = GAP;
                     gap_cnt_d = '0;
                  end
               end
`ifdef RESET_SEQ_TIMEOUT_EN
               if (to_hit) timeout_err_d = 1'b1;
               if (!ack_ok) wait_cnt_d = wait_cnt_q + TO_W'(1);
`endif
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = RELEASE;
                  idx_d   = idx_q + IDX_W'(1);
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // The stage being released drops its reset for the RELEASE cycle onward
      if (state_d == RELEASE) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_d == IDX_W'(k)) stage_rst_d[k] = 1'b0;
         end
      end
   end

   // State and registered outputs; block reset starts a full sequence from HOLD
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= HOLD;
         hold_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         idx_q         <= '0;
         stage_rst_q   <= '1;
         busy_q        <= 1'b1;
         done_q        <= 1'b0;
         req_count_q   <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         idx_q         <= idx_d;
         stage_rst_q   <= stage_rst_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         req_count_q   <= req_count_d;
`ifdef RESET_SEQ_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign STAGE_RST = stage_rst_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign REQ_COUNT = req_count_q;
`ifdef RESET_SEQ_TIMEOUT_EN
   assign TIMEOUT_ERR = timeout_err_q;
`endif

endmodule
